// File: rtl/simon_seq_ctrl.sv
// simon_seq_ctrl: plays back pattern entries 0..level on leds, then checks player presses against them
module simon_seq_ctrl #(
  parameter int ON_TICKS  = 4,
  parameter int GAP_TICKS = 2,
  parameter int TW        = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [7:0]  level,
  output logic        mem_en,
  output logic [7:0]  mem_sel,
  input  logic [11:0] mem_btns,
  output logic [11:0] leds,
  output logic        in_ready,
  input  logic [11:0] in_btns,
  output logic        busy,
  output logic        pass,
  output logic        fail
);
  typedef enum logic [3:0] {
    IDLE, FETCH, LOAD, SHOW, GAP, IFETCH, ILOAD, WAIT_IN, PASS, FAIL
  } state_t;
  state_t state_q, state_d;
  logic [7:0] idx_q, idx_d, last_q, last_d;
  logic [11:0] pat_q, pat_d;
  logic [TW-1:0] timer_q, timer_d;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      pat_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      pat_q   <= pat_d;
      timer_q <= timer_d;
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    pat_d   = pat_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: if (start) begin
        last_d  = level;
        idx_d   = '0;
        state_d = FETCH;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        pat_d   = mem_btns;
        timer_d = TW'(ON_TICKS);
        state_d = SHOW;
      end
      SHOW: if (timer_q == TW'(1)) begin
        timer_d = TW'(GAP_TICKS);
        state_d = GAP;
      end else timer_d = timer_q - TW'(1);
      GAP: if (timer_q == TW'(1)) begin
        idx_d   = (idx_q == last_q) ? 8'd0 : idx_q + 8'd1;
        state_d = (idx_q == last_q) ? IFETCH : FETCH;
      end else timer_d = timer_q - TW'(1);
      IFETCH: state_d = ILOAD;
      ILOAD: begin
        pat_d   = mem_btns;
        state_d = WAIT_IN;
      end
      WAIT_IN: if (in_btns != '0) begin
        if (in_btns != pat_q) state_d = FAIL;
        else if (idx_q == last_q) state_d = PASS;
        else begin
          idx_d   = idx_q + 8'd1;
          state_d = IFETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign mem_en   = (state_q == FETCH) || (state_q == IFETCH);
  assign mem_sel  = (state_q == IDLE) ? 8'd0 : idx_q;
  assign leds     = (state_q == SHOW) ? pat_q : 12'd0;
  assign in_ready = state_q == WAIT_IN;
  assign busy     = state_q != IDLE;
  assign pass     = state_q == PASS;
  assign fail     = state_q == FAIL;
endmodule

// File: tb/tb_simon_seq_ctrl.sv
// tb_simon_seq_ctrl: randomized self-checking bench with a timeline model of a round
module tb_simon_seq_ctrl;
  localparam int ON = 4, GP = 2, P = 2 + ON + GP;
  logic clk = 0, n_rst, start, mem_en, in_ready, busy, pass, fail;
  logic [7:0] level, mem_sel;
  logic [11:0] mem_btns, leds, in_btns;
  logic [11:0] mem [256];
  int checks = 0, errors = 0;
  simon_seq_ctrl #(.ON_TICKS(ON), .GAP_TICKS(GP), .TW(8)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .level(level), .mem_en(mem_en),
    .mem_sel(mem_sel), .mem_btns(mem_btns), .leds(leds), .in_ready(in_ready),
    .in_btns(in_btns), .busy(busy), .pass(pass), .fail(fail)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_en) mem_btns <= mem[mem_sel];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: mode 0 idle, 1 playback (k = cycles since first fetch), 2 entry, 3 pass, 4 fail
  int m_mode, m_k, m_last, m_ic, m_step;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_mode <= 0; m_k <= 0; m_last <= 0; m_ic <= 0; m_step <= 0;
    end else case (m_mode)
      0: if (start) begin m_mode <= 1; m_k <= 0; m_last <= int'(level); end
      1: if (m_k == (m_last + 1) * P - 1) begin m_mode <= 2; m_step <= 0; m_ic <= 0; end
         else m_k <= m_k + 1;
      2: if (m_ic < 2) m_ic <= m_ic + 1;
         else if (in_btns != 0) begin
           if (in_btns != mem[m_step]) m_mode <= 4;
           else if (m_step == m_last) m_mode <= 3;
           else begin m_step <= m_step + 1; m_ic <= 0; end
         end
      default: m_mode <= 0;
    endcase
  end
  always @(posedge clk) begin
    logic e_en, e_rdy;
    logic [7:0] e_sel;
    logic [11:0] e_leds;
    int r;
    #1;
    r = m_k % P;
    e_en = (m_mode == 1 && r == 0) || (m_mode == 2 && m_ic == 0);
    e_sel = m_mode == 1 ? 8'(m_k / P) : (m_mode == 0 ? 8'd0 : 8'(m_step));
    e_leds = (m_mode == 1 && r >= 2 && r < 2 + ON) ? mem[m_k / P] : 12'd0;
    e_rdy = m_mode == 2 && m_ic >= 2;
    chk("cycle_outputs", {mem_en, mem_sel, leds, in_ready, busy, pass, fail},
        {e_en, e_sel, e_leds, e_rdy, m_mode != 0, m_mode == 3, m_mode == 4});
  end
  task automatic press(input logic [11:0] v);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 5000) begin
      in_btns = ($urandom % 3 == 0) ? 12'($urandom_range(1, 4095)) : 12'd0;
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL ready_timeout: in_ready stayed 0 expected 1");
    end
    in_btns = v;
    @(negedge clk);
    in_btns = 0;
  endtask
  task automatic go(input logic [7:0] lv);
    start = 1; level = lv;
    @(negedge clk);
    start = 0;
  endtask
  initial begin
    foreach (mem[i]) mem[i] = 12'($urandom_range(1, 4095));
    mem[0] = 12'h001; mem[1] = 12'h010; mem[2] = 12'h800;
    n_rst = 0; start = 0; level = 0; in_btns = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {mem_en, mem_sel, leds, in_ready, busy, pass, fail}, 0);
    n_rst = 1;
    @(negedge clk);
    in_btns = 12'h001;
    @(negedge clk);
    in_btns = 0;
    chk("idle_press_ignored", busy, 0);
    go(8'd2);
    chk("fetch_first", {mem_en, mem_sel}, {1'b1, 8'd0});
    repeat (2) @(negedge clk);
    chk("first_leds", leds, 12'h001);
    start = 1;
    @(negedge clk);
    start = 0;
    press(12'h001); press(12'h010); press(12'h800);
    chk("pass_pulse", {pass, fail}, 2'b10);
    @(negedge clk);
    chk("pass_done", {pass, busy}, 2'b00);
    go(8'd2);
    press(12'h001); press(12'h800);
    chk("fail_pulse", {pass, fail}, 2'b01);
    @(negedge clk);
    go(8'd2);
    chk("replay_from_0", {mem_en, mem_sel}, {1'b1, 8'd0});
    press(12'h001); press(12'h010); press(12'h800);
    chk("pass_again", pass, 1);
    @(negedge clk);
    go(8'd0);
    press(12'h001);
    chk("level0_pass", pass, 1);
    @(negedge clk);
    go(8'd2);
    for (int n = 0; n < 100 && !(mem_sel == 1 && leds != 0); n++) @(negedge clk);
    for (int n = 0; n < 100 && leds != 0; n++) @(negedge clk);
    chk("in_gap_step1", {mem_sel, leds, busy}, {8'd1, 12'd0, 1'b1});
    #2 n_rst = 0;
    #1 chk("async_reset", {mem_en, mem_sel, leds, in_ready, busy, pass, fail}, 0);
    repeat (2) @(negedge clk);
    n_rst = 1;
    @(negedge clk);
    chk("after_reset_idle", busy, 0);
    go(8'd2);
    chk("reset_replay_0", {mem_en, mem_sel}, {1'b1, 8'd0});
    press(12'h001); press(12'h010); press(12'h800);
    chk("reset_round_pass", pass, 1);
    @(negedge clk);
    for (int r = 0; r < 12; r++) begin
      int lv = $urandom_range(0, 5);
      go(8'(lv));
      for (int i = 0; i <= lv; i++) begin
        press(($urandom % 6 == 0) ? 12'($urandom_range(1, 4095)) : mem[i]);
        if (pass || fail) break;
      end
      @(negedge clk);
    end
    go(8'd255);
    for (int i = 0; i <= 255; i++) press(mem[i]);
    chk("wrap_255_pass", pass, 1);
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
